// File: rtl/trivium_uart_tx.sv
// Output-side UART transmitter for the Trivium core: 8 data bits LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module trivium_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_tx,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop_bits
    $error("trivium_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : gen_bad_clks_per_bit
    $error("trivium_uart_tx: CLKS_PER_BIT must be >= 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            line_q, line_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            wrap;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    line_d    = line_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_valid && ready_q) begin
          state_d   = StStart;
          shreg_d   = tx_data;
          line_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      StStart: begin
        if (wrap) begin
          state_d = StData;
          cnt_d   = '0;
          line_d  = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (wrap) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
            line_d    = parity_q;
`else
            state_d   = StStop;
            line_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            line_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          cnt_d   = '0;
          line_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (wrap) begin
          cnt_d = '0;
          // bit_cnt is reused to count stop bits
          if (bit_cnt_q == StopLast) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    ready_d = ena && (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign serial_tx = line_q;
  assign busy      = busy_q;
  assign tx_ready  = ready_q;

endmodule

// File: tb/tb_trivium_uart_tx.sv
// Directed self-checking bench for trivium_uart_tx at CLKS_PER_BIT=4.
`timescale 1ns/1ps
module tb_trivium_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int NBITS = 10 + SB - 1 + PB;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       serial_tx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  time t1, t2, hs_time;

  trivium_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .serial_tx(serial_tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level for each bit slot of a frame, slot 0 = start bit.
  function automatic logic [15:0] frame_bits(input logic [7:0] b);
    logic [15:0] p;
    p    = '1;
    p[0] = 1'b0;
    for (int k = 0; k < 8; k++) p[1+k] = b[k];
`ifdef UART_TX_PARITY_EN
    p[9] = ^b;
`endif
    return p;
  endfunction

  // Presents a byte and returns just after the accepting rising edge.
  task automatic handshake(input logic [7:0] b, input bit hold);
    int n;
    n        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", tx_ready, 1'b1);
    @(posedge clk);
    hs_time = $time;
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic check_frame(input logic [15:0] pat, input int drop_ena_at, input int zero_at);
    for (int i = 0; i < NBITS * CPB; i++) begin
      @(negedge clk);
      check("line", serial_tx, pat[i / CPB]);
      check("busy", busy, 1'b1);
      check("ready_low", tx_ready, 1'b0);
      if (i == drop_ena_at) ena = 1'b0;
      if (i == zero_at) tx_data = 8'h00;
    end
    @(negedge clk);
    check("busy_end", busy, 1'b0);
    check("line_idle", serial_tx, 1'b1);
    check("ready_end", tx_ready, ena);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    ena      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_line", serial_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", tx_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1'b1);

    // 1: A5, hand-computed line sequence
    handshake(8'hA5, 1'b0);
`ifdef UART_TX_PARITY_EN
    check_frame(frame_bits(8'hA5), -1, -1);
`else
    check_frame(16'b0000_0011_0100_1010, -1, -1);
`endif

    // 2: back-to-back with tx_valid held high
    handshake(8'h3C, 1'b1);
    t1      = hs_time;
    tx_data = 8'h7F;
    check_frame(frame_bits(8'h3C), -1, -1);
    handshake(8'h7F, 1'b0);
    t2 = hs_time;
    check("start_gap", int'((t2 - t1) / 10), NBITS * CPB + 1);
    check_frame(frame_bits(8'h7F), -1, -1);

    // 3: ena dropped mid-frame, pending byte must wait
    handshake(8'hC1, 1'b0);
    check_frame(frame_bits(8'hC1), 10, -1);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("ena_off_ready", tx_ready, 1'b0);
      check("ena_off_busy", busy, 1'b0);
      check("ena_off_line", serial_tx, 1'b1);
    end
    ena = 1'b1;
    handshake(8'h5A, 1'b0);
    check_frame(frame_bits(8'h5A), -1, -1);

    // 4: reset during data bit 3 of 99
    handshake(8'h99, 1'b0);
    repeat (18) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_line", serial_tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", tx_ready, 1'b1);
    handshake(8'h42, 1'b0);
    check_frame(frame_bits(8'h42), -1, -1);

    // 5: tx_data changed after handshake has no effect
    handshake(8'hE7, 1'b0);
    check_frame(frame_bits(8'hE7), -1, 0);

`ifdef UART_TX_PARITY_EN
    // 6: even parity of B8 is 0, 12-bit frame
    handshake(8'hB8, 1'b0);
    check_frame(frame_bits(8'hB8), -1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
